// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Included by every fetch-side module through a package import.
package cpu_pkg;

    localparam int XLEN       = 64;
    localparam int ILEN       = 32;
    localparam int INST_BYTES = 4;

    localparam logic [XLEN-1:0] RESET_ADDR_DEFAULT = '0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with flush; head is visible combinationally.
// Used both for fetched instructions and for in-flight request addresses.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  T                             wdata,
    output T                             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    T             mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A push into a full queue is only legal when the head leaves the same cycle.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch front end: owns the fetch PC, issues in-order memory requests,
// buffers responses and presents {pc, pc4, inst} to the IF/ID register.
module inst_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = XLEN,
    parameter int                    INST_WIDTH = ILEN,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(RESET_ADDR_DEFAULT),
    parameter int                    FQ_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    output logic                  inst_valid,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc4,
    output logic [INST_WIDTH-1:0] inst,
    output logic                  fq_empty,
    output logic                  fq_full
);

    localparam int CW = $clog2(FQ_DEPTH + 1);

    typedef logic [ADDR_WIDTH-1:0] addr_t;

    addr_t        fetch_pc;
    addr_t        fp;
    addr_t        tag_addr;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fq_count;
    logic [CW-1:0] out_n;
    logic [CW-1:0] cnt_n;
    logic [CW-1:0] tag_count;
    logic          hs;
    logic          hold;
    logic          push;
    logic          pop;
    logic          issue;
    logic          tag_empty;
    logic          tag_full;
    logic          unused_tag;
    fetch_entry_t  head;
    fetch_entry_t  wentry;

    assign hs    = imem_req_valid & imem_req_ready;
    assign hold  = imem_req_valid & ~imem_req_ready;
    assign push  = imem_rsp_valid & (drop_cnt == '0) & ~redirect_valid;
    assign pop   = inst_valid & ~stall;
    assign fp    = redirect_valid ? redirect_pc : fetch_pc;
    assign out_n = outstanding + CW'(hs) - CW'(imem_rsp_valid);
    assign cnt_n = redirect_valid ? '0 : fq_count + CW'(push) - CW'(pop);
    // Credit check on next-cycle occupancy so a full queue is never overrun.
    assign issue = ~hold & (({1'b0, out_n} + {1'b0, cnt_n}) < (CW+1)'(FQ_DEPTH));

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            fetch_pc       <= RESET_ADDR;
            imem_req_valid <= 1'b0;
            imem_req_addr  <= RESET_ADDR;
            outstanding    <= '0;
            drop_cnt       <= '0;
        end else begin
            outstanding <= out_n;
            if (redirect_valid)
                drop_cnt <= out_n + CW'(hold);
            else if (imem_rsp_valid && drop_cnt != '0)
                drop_cnt <= drop_cnt - 1'b1;
            if (!hold) begin
                imem_req_valid <= issue;
                if (issue) imem_req_addr <= fp;
            end
            fetch_pc <= issue ? fp + ADDR_WIDTH'(INST_BYTES) : fp;
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH),
        .T     (addr_t)
    ) u_tag_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (hs),
        .pop   (imem_rsp_valid),
        .flush (1'b0),
        .wdata (imem_req_addr),
        .rdata (tag_addr),
        .count (tag_count),
        .empty (tag_empty),
        .full  (tag_full)
    );

    assign unused_tag = ^{tag_count, tag_empty, tag_full};
    assign wentry     = '{pc: tag_addr, inst: imem_rsp_data};

    fetch_queue #(
        .DEPTH (FQ_DEPTH),
        .T     (fetch_entry_t)
    ) u_fetch_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wentry),
        .rdata (head),
        .count (fq_count),
        .empty (fq_empty),
        .full  (fq_full)
    );

    assign inst_valid = ~fq_empty;
    assign pc         = inst_valid ? head.pc : '0;
    assign pc4        = inst_valid ? head.pc + ADDR_WIDTH'(INST_BYTES) : '0;
    assign inst       = inst_valid ? head.inst : '0;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios plus random traffic
// checked against an instruction-stream reference model.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic [63:0] pc;
    logic [63:0] pc4;
    logic [31:0] inst;
    logic        fq_empty;
    logic        fq_full;

    always #5 clk = ~clk;

    inst_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .pc             (pc),
        .pc4            (pc4),
        .inst           (inst),
        .fq_empty       (fq_empty),
        .fq_full        (fq_full)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9bdf;
    endfunction

    // knobs
    bit          stall_k, ready_k, redir_k, redir_on_rsp;
    logic [63:0] redir_pc_k;
    int          lat_k;

    // reference model and memory
    logic [63:0] exp_pc;
    logic [63:0] prev_addr;
    logic [63:0] last_hs_addr;
    logic [63:0] pend_addr [$];
    int          pend_due  [$];
    int          n_out, cyc, hs_cnt, tb_out, wraps;
    bit          prev_hold, after_redir;

    logic        s_req_valid, s_iv, s_empty, s_full;
    logic [63:0] s_req_addr, s_pc, s_pc4;
    logic [31:0] s_inst;

    task automatic cycle();
        @(negedge clk);
        cyc++;
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_iv        = inst_valid;
        s_pc        = pc;
        s_pc4       = pc4;
        s_inst      = inst;
        s_empty     = fq_empty;
        s_full      = fq_full;
        if (prev_hold) begin
            chk("hold_valid", s_req_valid, 1);
            chk("hold_addr", s_req_addr, prev_addr);
        end
        chk("valid_vs_empty", s_iv, !s_empty);
        if (after_redir) begin
            chk("flush_iv", s_iv, 0);
            chk("flush_empty", s_empty, 1);
        end
        if (!s_iv) chk("idle_zero", s_pc | s_pc4 | s_inst, 0);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
            tb_out--;
        end
        stall          = stall_k;
        imem_req_ready = ready_k;
        redirect_valid = redir_k || (redir_on_rsp && imem_rsp_valid);
        redirect_pc    = redir_pc_k;
        if (s_req_valid && ready_k) begin
            pend_addr.push_back(s_req_addr);
            pend_due.push_back(cyc + lat_k);
            tb_out++;
            hs_cnt++;
            last_hs_addr = s_req_addr;
        end
        if (s_iv && !stall_k) begin
            chk("pc", s_pc, exp_pc);
            chk("pc4", s_pc4, exp_pc + 64'd4);
            chk("inst", s_inst, mem_word(exp_pc));
            if (exp_pc == 64'hFFFF_FFFF_FFFF_FFFC) wraps++;
            exp_pc = exp_pc + 64'd4;
            n_out++;
        end
        if (redirect_valid) exp_pc = redirect_pc;
        after_redir = redirect_valid;
        prev_hold   = s_req_valid && !ready_k;
        prev_addr   = s_req_addr;
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b1;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        stall          = 1'b0;
        imem_req_ready = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        tb_out      = 0;
        prev_hold   = 0;
        after_redir = 0;
        exp_pc      = '0;
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_req_addr", imem_req_addr, 0);
        chk("rst_iv", inst_valid, 0);
        chk("rst_fields", pc | pc4 | inst, 0);
        chk("rst_empty", fq_empty, 1);
        chk("rst_full", fq_full, 0);
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    initial begin
        int first_iv;
        int n0;
        int h0;
        rst_n = 1'b1; stall = 0; redirect_valid = 0; redirect_pc = '0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
        stall_k = 0; ready_k = 1; redir_k = 0; redir_on_rsp = 0;
        redir_pc_k = '0; lat_k = 1;
        n_out = 0; cyc = 0; hs_cnt = 0; wraps = 0;

        // 1: back-to-back issue, first instruction two cycles after first request
        do_reset();
        first_iv = -1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (i < 4) begin
                chk("t1_req_valid", s_req_valid, 1);
                chk("t1_req_addr", s_req_addr, 64'(4 * i));
            end
            if (s_iv && first_iv < 0) first_iv = i;
        end
        chk("t1_first_iv", 64'(first_iv), 2);

        // 2: stalled consumer fills the queue after exactly four requests
        stall_k = 1;
        do_reset();
        h0 = hs_cnt;
        repeat (10) cycle();
        chk("t2_reqs", 64'(hs_cnt - h0), 4);
        chk("t2_full", s_full, 1);
        chk("t2_req_valid", s_req_valid, 0);
        stall_k = 0;
        n0 = n_out;
        repeat (12) cycle();
        chk("t2_drain", 64'(n_out - n0 >= 4), 1);

        // 3: redirect with three responses in flight
        lat_k = 4;
        do_reset();
        for (int i = 0; i < 20 && tb_out < 3; i++) cycle();
        chk("t3_outstanding", 64'(tb_out), 3);
        redir_k = 1; redir_pc_k = 64'h1000;
        cycle();
        redir_k = 0; lat_k = 1;
        n0 = n_out;
        repeat (20) cycle();
        chk("t3_progress", 64'(n_out - n0 >= 4), 1);

        // 4: redirect while the request is held by memory
        ready_k = 0;
        do_reset();
        repeat (2) cycle();
        redir_k = 1; redir_pc_k = 64'h1000;
        cycle();
        redir_k = 0;
        repeat (2) cycle();
        chk("t4_held_valid", s_req_valid, 1);
        chk("t4_held_addr", s_req_addr, 0);
        ready_k = 1;
        cycle();
        chk("t4_first_hs", last_hs_addr, 0);
        n0 = n_out;
        repeat (15) cycle();
        chk("t4_progress", 64'(n_out - n0 >= 4), 1);

        // 5: redirect coinciding with a response
        do_reset();
        redir_pc_k = 64'h2000; redir_on_rsp = 1;
        for (int i = 0; i < 10 && !after_redir; i++) cycle();
        redir_on_rsp = 0;
        chk("t5_fired", after_redir, 1);
        n0 = n_out;
        repeat (15) cycle();
        chk("t5_progress", 64'(n_out - n0 >= 4), 1);

        // 6: pc wrap, then asynchronous reset mid-burst
        do_reset();
        redir_k = 1; redir_pc_k = 64'hFFFF_FFFF_FFFF_FFF8;
        cycle();
        redir_k = 0;
        wraps = 0;
        repeat (12) cycle();
        chk("t6_wrapped", 64'(wraps), 1);
        stall_k = 1;
        repeat (3) cycle();
        chk("t6_pre_iv", s_iv, 1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("t6_async_iv", inst_valid, 0);
        chk("t6_async_req", imem_req_valid, 0);
        chk("t6_async_empty", fq_empty, 1);
        chk("t6_async_pc", pc | pc4 | inst, 0);
        stall_k = 0;

        // random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            stall_k = ($urandom % 10) < 3;
            ready_k = ($urandom % 10) < 7;
            lat_k   = 1 + int'($urandom % 4);
            redir_k = ($urandom % 100) < 3;
            if ($urandom % 4 == 0)
                redir_pc_k = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(3)) * 64'd4;
            else
                redir_pc_k = {$urandom, $urandom} & ~64'h3;
            cycle();
        end
        stall_k = 0; ready_k = 1; redir_k = 0; lat_k = 1;
        n0 = n_out;
        repeat (30) cycle();
        chk("rand_drain", 64'(n_out - n0 >= 10), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
